// File: rtl/mem_subword_ctrl_if.sv
// LSU request/response channel plus the word-only memory read/write ports.
// master = LSU/memory side, slave = mem_subword_ctrl.
interface mem_subword_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_err;

  logic [ADDR_W-1:0] mem_read_address;
  logic [31:0]       mem_read_data;
  logic              mem_read_exc;
  logic              mem_write_enable;
  logic [ADDR_W-1:0] mem_write_address;
  logic [31:0]       mem_write_data;
  logic              mem_write_exc;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_err,
    output rsp_ready,
    input  mem_read_address, mem_write_enable, mem_write_address, mem_write_data,
    output mem_read_data, mem_read_exc, mem_write_exc
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_data, rsp_err,
    input  rsp_ready,
    output mem_read_address, mem_write_enable, mem_write_address, mem_write_data,
    input  mem_read_data, mem_read_exc, mem_write_exc
  );
endinterface

// File: rtl/mem_subword_ctrl.sv
// Byte/half/word load-store sequencer for a word-only memory; sub-word stores are read-modify-write.
// Response 1 (reject), 2 (load, word store) or 3 (sub-word store) cycles after accept; one request in flight, held until rsp_ready.
module mem_subword_ctrl #(
  parameter int ADDR_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  mem_subword_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, req_addr_eff;
  logic [1:0]        size_q;
  logic              signed_q, write_q;
  logic [31:0]       wdata_q, rsp_data_q;
  logic              rsp_err_q;

  logic              accept, size_bad, misaligned, reject;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_val, merged;

  assign accept = bus.req_valid && bus.req_ready;

  // Alignment is always forced; with CHECK_ALIGN set the misaligned case never gets this far.
  always_comb begin
    size_bad     = (bus.req_size == 2'd3);
    misaligned   = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                   ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));
    reject       = size_bad || (CHECK_ALIGN && misaligned);
    req_addr_eff = bus.req_addr;
    if (bus.req_size == 2'd1) req_addr_eff[0]   = 1'b0;
    if (bus.req_size == 2'd2) req_addr_eff[1:0] = 2'b00;
  end

  always_comb begin
    rd_byte = bus.mem_read_data[{addr_q[1:0], 3'b000} +: 8];
    rd_half = bus.mem_read_data[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'd0:    load_val = {{24{signed_q & rd_byte[7]}}, rd_byte};
      2'd1:    load_val = {{16{signed_q & rd_half[15]}}, rd_half};
      default: load_val = bus.mem_read_data;
    endcase
    merged = bus.mem_read_data;
    if (size_q == 2'd0)      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else if (size_q == 2'd1) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (reject)                                         state_nxt = RESP;
          else if (!bus.req_write || (bus.req_size != 2'd2)) state_nxt = READ;
          else                                                state_nxt = WRITE;
        end
      end
      READ: begin
        if (bus.mem_read_exc) state_nxt = RESP;
        else if (write_q)     state_nxt = WRITE;
        else                  state_nxt = RESP;
      end
      WRITE:   state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      addr_q     <= '0;
      size_q     <= 2'd0;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= 32'd0;
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q     <= req_addr_eff;
            size_q     <= bus.req_size;
            signed_q   <= bus.req_signed;
            write_q    <= bus.req_write;
            wdata_q    <= bus.req_wdata;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= reject;
          end
        end
        READ: begin
          if (bus.mem_read_exc) rsp_err_q  <= 1'b1;
          else if (write_q)     wdata_q    <= merged;
          else                  rsp_data_q <= load_val;
        end
        WRITE:   rsp_err_q <= bus.mem_write_exc;
        default: ;
      endcase
    end
  end

  // req_ready is gated by reset directly so it stays low while reset is held.
  assign bus.req_ready         = (state == IDLE) && RESET_N;
  assign bus.rsp_valid         = (state == RESP);
  assign bus.rsp_data          = rsp_data_q;
  assign bus.rsp_err           = rsp_err_q;
  assign bus.mem_read_address  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_write_address = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_write_enable  = (state == WRITE);
  assign bus.mem_write_data    = wdata_q;
endmodule
